// File: rtl/syn_rx.sv
// Serial seconds receiver: decodes 8N1 frames carrying a seconds value and
// keeps a free-running local seconds counter resynchronised to each accepted value.
module syn_rx #(
   parameter int CLKS_PER_BIT  = 1042,
   parameter int TICKS_PER_SEC = 10000000,
   parameter int SEC_MAX       = 59
) (
   input  logic       clk_10M,
   input  logic       rst,
   input  logic       data_from_master,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic [7:0] local_second,
   output logic       hz_tick,
   output logic       locked
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [SUB_W-1:0]  SUB_ONE   = SUB_W'(1);
   localparam logic [7:0]        SEC_LIMIT = 8'(SEC_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic              sync_1, sync_2, line_prev;
   logic              line_fall;
   logic [BAUD_W-1:0] baud_cnt, baud_cnt_nxt;
   logic [2:0]        bit_cnt, bit_cnt_nxt;
   logic [7:0]        shift_reg, shift_nxt;
   logic              frame_done;
   logic              frame_ok;
   logic [SUB_W-1:0]  sub_cnt;

   // Line resets to the idle level so release never looks like a start bit.
   always_ff @(posedge clk_10M or posedge rst) begin
      if (rst) begin
         sync_1    <= 1'b1;
         sync_2    <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync_1    <= data_from_master;
         sync_2    <= sync_1;
         line_prev <= sync_2;
      end
   end

   assign line_fall = line_prev & ~sync_2;

   always_ff @(posedge clk_10M or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt;
      bit_cnt_nxt  = bit_cnt;
      shift_nxt    = shift_reg;
      frame_done   = 1'b0;
      case (state)
         IDLE: begin
            if (line_fall) begin
               state_nxt    = START;
               baud_cnt_nxt = '0;
               bit_cnt_nxt  = '0;
            end
         end
         START: begin
            if (baud_cnt == HALF_LAST) begin
               baud_cnt_nxt = '0;
               state_nxt    = sync_2 ? IDLE : DATA;
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         DATA: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt = '0;
               shift_nxt    = {sync_2, shift_reg[7:1]};
               bit_cnt_nxt  = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_nxt = '0;
               frame_done   = 1'b1;
               state_nxt    = IDLE;
            end else begin
               baud_cnt_nxt = baud_cnt + BAUD_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign frame_ok = frame_done & sync_2 & (shift_reg <= SEC_LIMIT);

   always_ff @(posedge clk_10M or posedge rst) begin
      if (rst) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         locked    <= 1'b0;
      end else begin
         rx_valid  <= frame_ok;
         frame_err <= frame_done & ~frame_ok;
         if (frame_ok) begin
            rx_data <= shift_reg;
            locked  <= 1'b1;
         end
      end
   end

   // A received value overrides a coincident terminal count, so no tick is lost or doubled.
   always_ff @(posedge clk_10M or posedge rst) begin
      if (rst) begin
         sub_cnt      <= '0;
         local_second <= '0;
         hz_tick      <= 1'b0;
      end else begin
         hz_tick <= 1'b0;
         if (frame_ok) begin
            sub_cnt      <= '0;
            local_second <= shift_reg;
         end else if (sub_cnt == SUB_LAST) begin
            sub_cnt      <= '0;
            hz_tick      <= 1'b1;
            local_second <= (local_second >= SEC_LIMIT) ? 8'd0 : local_second + 8'd1;
         end else begin
            sub_cnt <= sub_cnt + SUB_ONE;
         end
      end
   end

endmodule

// File: tb/tb_syn_rx.sv
// Directed self-checking bench for syn_rx: frames, rejects, glitch, seconds wrap,
// load-versus-tick priority and mid-frame reset.
module tb_syn_rx;

   localparam int CPB  = 16;
   localparam int TPS  = 100;
   localparam int SMAX = 59;

   logic       clk_10M = 1'b0;
   logic       rst;
   logic       data_from_master;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic [7:0] local_second;
   logic       hz_tick;
   logic       locked;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   int ref_cyc   = 0;
   int ref_val   = 0;
   int load_cyc  = 0;

   syn_rx #(
      .CLKS_PER_BIT (CPB),
      .TICKS_PER_SEC(TPS),
      .SEC_MAX      (SMAX)
   ) dut (
      .clk_10M         (clk_10M),
      .rst             (rst),
      .data_from_master(data_from_master),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .frame_err       (frame_err),
      .local_second    (local_second),
      .hz_tick         (hz_tick),
      .locked          (locked)
   );

   always #5 clk_10M = ~clk_10M;

   always @(posedge clk_10M) cyc <= cyc + 1;

   always @(negedge clk_10M) begin
      if (rx_valid)  valid_cnt <= valid_cnt + 1;
      if (frame_err) err_cnt   <= err_cnt + 1;
   end

   // Expected local seconds/sub-count from the last load point and elapsed clock edges.
   function automatic int exp_sec();
      return (ref_val + (cyc - ref_cyc) / TPS) % (SMAX + 1);
   endfunction

   function automatic int exp_sub();
      return (cyc - ref_cyc) % TPS;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Called on a falling clock edge; returns on the cycle after the stop-bit sample.
   task automatic applyStimulus(input logic [7:0] value, input logic stop_bit);
      data_from_master = 1'b0;
      repeat (CPB) @(negedge clk_10M);
      for (int i = 0; i < 8; i++) begin
         data_from_master = value[i];
         repeat (CPB) @(negedge clk_10M);
      end
      data_from_master = stop_bit;
      repeat (CPB / 2 + 3) @(negedge clk_10M);
   endtask

   task automatic finishFrame();
      @(negedge clk_10M);
      checkOutput("valid_one_cycle", 32'(rx_valid), 32'd0);
      checkOutput("err_one_cycle", 32'(frame_err), 32'd0);
      repeat (4) @(negedge clk_10M);
      data_from_master = 1'b1;
      repeat (8) @(negedge clk_10M);
   endtask

   initial begin
      rst              = 1'b1;
      data_from_master = 1'b1;
      repeat (3) @(negedge clk_10M);
      checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("rst_local_second", 32'(local_second), 32'd0);
      checkOutput("rst_hz_tick", 32'(hz_tick), 32'd0);
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_sub_cnt", 32'(dut.sub_cnt), 32'd0);

      rst     = 1'b0;
      ref_cyc = cyc;
      ref_val = 0;
      repeat (5) @(negedge clk_10M);
      checkOutput("idle_locked", 32'(locked), 32'd0);
      checkOutput("idle_sub_cnt", 32'(dut.sub_cnt), 32'(exp_sub()));

      $display("[TB] frame 0x2A");
      applyStimulus(8'h2A, 1'b1);
      checkOutput("2a_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("2a_frame_err", 32'(frame_err), 32'd0);
      checkOutput("2a_rx_data", 32'(rx_data), 32'h2A);
      checkOutput("2a_local_second", 32'(local_second), 32'd42);
      checkOutput("2a_locked", 32'(locked), 32'd1);
      checkOutput("2a_sub_cnt", 32'(dut.sub_cnt), 32'd0);
      ref_cyc = cyc;
      ref_val = 42;
      finishFrame();
      checkOutput("2a_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("2a_err_count", 32'(err_cnt), 32'd0);

      $display("[TB] frame 0x3C out of range");
      applyStimulus(8'h3C, 1'b1);
      checkOutput("3c_frame_err", 32'(frame_err), 32'd1);
      checkOutput("3c_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("3c_rx_data", 32'(rx_data), 32'h2A);
      checkOutput("3c_locked", 32'(locked), 32'd1);
      checkOutput("3c_local_second", 32'(local_second), 32'(exp_sec()));
      checkOutput("3c_sub_cnt", 32'(dut.sub_cnt), 32'(exp_sub()));
      finishFrame();
      checkOutput("3c_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("3c_err_count", 32'(err_cnt), 32'd1);

      $display("[TB] frame 0x15 with bad stop bit");
      applyStimulus(8'h15, 1'b0);
      checkOutput("15_frame_err", 32'(frame_err), 32'd1);
      checkOutput("15_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("15_rx_data", 32'(rx_data), 32'h2A);
      checkOutput("15_local_second", 32'(local_second), 32'(exp_sec()));
      finishFrame();
      checkOutput("15_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("15_err_count", 32'(err_cnt), 32'd2);

      $display("[TB] 3-cycle glitch");
      data_from_master = 1'b0;
      repeat (3) @(negedge clk_10M);
      data_from_master = 1'b1;
      repeat (20) @(negedge clk_10M);
      checkOutput("glitch_state_idle", 32'(dut.state), 32'd0);
      checkOutput("glitch_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("glitch_err_count", 32'(err_cnt), 32'd2);

      $display("[TB] load 59 and wrap");
      applyStimulus(8'h3B, 1'b1);
      checkOutput("3b_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("3b_local_second", 32'(local_second), 32'd59);
      ref_cyc  = cyc;
      ref_val  = 59;
      load_cyc = cyc;
      finishFrame();
      while (cyc < load_cyc + TPS - 1) @(negedge clk_10M);
      checkOutput("wrap_hz_before", 32'(hz_tick), 32'd0);
      checkOutput("wrap_sec_before", 32'(local_second), 32'd59);
      @(negedge clk_10M);
      checkOutput("wrap_hz_tick", 32'(hz_tick), 32'd1);
      checkOutput("wrap_local_second", 32'(local_second), 32'd0);

      $display("[TB] frame ending on terminal count");
      while (cyc < load_cyc + 3 * TPS - 155) @(negedge clk_10M);
      applyStimulus(8'h10, 1'b1);
      checkOutput("tc_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("tc_hz_tick", 32'(hz_tick), 32'd0);
      checkOutput("tc_local_second", 32'(local_second), 32'd16);
      checkOutput("tc_sub_cnt", 32'(dut.sub_cnt), 32'd0);
      ref_cyc = cyc;
      ref_val = 16;
      finishFrame();
      while (cyc < ref_cyc + TPS) @(negedge clk_10M);
      checkOutput("tc_next_hz_tick", 32'(hz_tick), 32'd1);
      checkOutput("tc_next_second", 32'(local_second), 32'd17);

      $display("[TB] reset during data bit 4");
      data_from_master = 1'b0;
      repeat (CPB) @(negedge clk_10M);
      for (int i = 0; i < 4; i++) begin
         data_from_master = 1'b1;
         repeat (CPB) @(negedge clk_10M);
      end
      data_from_master = 1'b0;
      repeat (CPB / 2) @(negedge clk_10M);
      rst              = 1'b1;
      data_from_master = 1'b1;
      #1;
      checkOutput("mid_rst_state", 32'(dut.state), 32'd0);
      checkOutput("mid_rst_rx_data", 32'(rx_data), 32'd0);
      checkOutput("mid_rst_local_second", 32'(local_second), 32'd0);
      checkOutput("mid_rst_locked", 32'(locked), 32'd0);
      checkOutput("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("mid_rst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("mid_rst_hz_tick", 32'(hz_tick), 32'd0);
      repeat (2) @(negedge clk_10M);
      rst     = 1'b0;
      ref_cyc = cyc;
      ref_val = 0;
      repeat (5) @(negedge clk_10M);

      applyStimulus(8'h07, 1'b1);
      checkOutput("07_rx_valid", 32'(rx_valid), 32'd1);
      checkOutput("07_rx_data", 32'(rx_data), 32'h07);
      checkOutput("07_local_second", 32'(local_second), 32'd7);
      checkOutput("07_locked", 32'(locked), 32'd1);
      finishFrame();
      checkOutput("final_valid_count", 32'(valid_cnt), 32'd4);
      checkOutput("final_err_count", 32'(err_cnt), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/syn_rx.md
SYN_RX -- requirements
Module: syn_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 1042, clk_10M cycles per serial bit (9600 baud at 10 MHz).
REQ-002 SHALL provide parameter TICKS_PER_SEC, default 10000000, clk_10M cycles per local second.
REQ-003 SHALL provide parameter SEC_MAX, default 59, largest legal seconds value.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk_10M  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 data_from_master  input  1  asynchronous serial line, idle high.
REQ-008 rx_data  output  8  last accepted seconds value.
REQ-009 rx_valid  output  1  one-cycle pulse on frame acceptance.
REQ-010 frame_err  output  1  one-cycle pulse on rejected frame.
REQ-011 local_second  output  8  free-running, resynchronised seconds count.
REQ-012 hz_tick  output  1  one-cycle pulse on each local second increment.
REQ-013 locked  output  1  high once any frame has been accepted.

Function
REQ-014 SHALL pass data_from_master through a 2-flop synchroniser; all decoding uses the synchronised signal only.
REQ-015 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE -> START on a synchronised 1->0 transition; the bit counter is cleared.
REQ-018 START SHALL resample at CLKS_PER_BIT/2 cycles (integer division); line low -> DATA, line high -> IDLE as a glitch (no error pulse).
REQ-019 DATA SHALL sample every CLKS_PER_BIT cycles after the start mid-point, shifting 8 bits LSB first, then go to STOP.
REQ-020 STOP SHALL sample one CLKS_PER_BIT after the last data bit and return to IDLE in the following cycle.
REQ-021 Frame accepted iff stop sample = 1 and data <= SEC_MAX: the cycle after the stop sample, rx_data updates and rx_valid pulses high for exactly 1 cycle.
REQ-022 Otherwise frame_err SHALL pulse for 1 cycle at the same point; rx_data, local_second and locked are unchanged.
REQ-023 A falling edge during START, DATA or STOP SHALL be ignored; no new frame starts until IDLE.
REQ-024 sub_cnt SHALL count 0..TICKS_PER_SEC-1; at the terminal count it wraps to 0, local_second increments (SEC_MAX wraps to 0), and hz_tick pulses.
REQ-025 On rx_valid cycle: local_second <= received value, sub_cnt <= 0, locked <= 1; load SHALL take priority over a coincident terminal count (no hz_tick, no increment).
REQ-026 sub_cnt width SHALL be ceil(log2(TICKS_PER_SEC)) bits; baud counter width SHALL be ceil(log2(CLKS_PER_BIT)) bits.
REQ-027 The local counter SHALL run whether or not locked is high.

Reset
REQ-028 While rst is high, regardless of clock: the FSM SHALL be IDLE; synchroniser flops SHALL be 1; rx_data, local_second, sub_cnt, and all counters SHALL be 0; rx_valid, frame_err, hz_tick, and locked SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; decoding resumes at the next falling edge after release.

Verification (CLKS_PER_BIT=16, TICKS_PER_SEC=100, SEC_MAX=59)
REQ-030 Scenario: send 0x2A, stop bit 1 -> rx_valid is 1 cycle, rx_data=0x2A, local_second=42, locked=1, sub_cnt=0.
REQ-031 Scenario: send 0x3C (60 > SEC_MAX) -> frame_err is 1 cycle, rx_data, local_second and locked are unchanged.
REQ-032 Scenario: send 0x15 with stop bit 0 -> frame_err pulse, no rx_valid.
REQ-033 Scenario: 3-cycle low glitch on an idle line -> FSM returns to IDLE, no pulses.
REQ-034 Scenario: after loading 59, run 100 cycles -> hz_tick pulse, local_second=0; frame completing on a terminal-count cycle -> loaded value wins, no hz_tick.
REQ-035 Scenario: assert rst during DATA bit 4 -> all outputs 0; after release, send 0x07 -> rx_data=0x07.
